// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display blocks.
//   - MODE_* : pattern-select encodings on the MODE input
//   - DEF_*  : default timing for the 800x480 panel (pixel counts / line counts)
//   - clog2  : ceiling log2, used to size counters from the timing parameters
package vga_pkg;

  localparam logic [1:0] MODE_BARS    = 2'd0;
  localparam logic [1:0] MODE_CHECKER = 2'd1;
  localparam logic [1:0] MODE_RAMP    = 2'd2;
  localparam logic [1:0] MODE_MBAR    = 2'd3;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 13;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 29;

  // Returns ceil(log2(value)); clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: pixel-enable divider plus horizontal/vertical counters.
// Ports:
//   clk, rst     : clock and asynchronous active-high reset
//   pe           : pixel enable, one clk cycle in every CLK_DIV
//   hcnt, vcnt   : current raster position
//   active       : position lies in the visible area
//   hs, vs       : sync intervals (active-high here; polarity applied by the user)
//   line_wrap    : pe on the last pixel of a line
//   frame_tick   : pe at position (0,0)
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pe,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          active,
  output logic          hs,
  output logic          vs,
  output logic          line_wrap,
  output logic          frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic h_last;
  logic v_last;

  generate
    if (CLK_DIV > 1) begin : g_div
      localparam int DW = clog2(CLK_DIV);
      logic [DW-1:0] div;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                          div <= '0;
        else if (div == DW'(CLK_DIV - 1)) div <= '0;
        else                              div <= div + 1'b1;
      end
      assign pe = (div == DW'(CLK_DIV - 1));
    end else begin : g_nodiv
      assign pe = 1'b1;
    end
  endgenerate

  assign h_last = (hcnt == HW'(H_TOTAL - 1));
  assign v_last = (vcnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pe) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  assign active     = (32'(hcnt) < 32'(H_ACTIVE)) && (32'(vcnt) < 32'(V_ACTIVE));
  assign hs         = (32'(hcnt) >= HS_START) && (32'(hcnt) < HS_END);
  assign vs         = (32'(vcnt) >= VS_START) && (32'(vcnt) < VS_END);
  assign line_wrap  = pe && h_last;
  assign frame_tick = pe && (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator.
// Ports:
//   CLOCK_50     : system clock
//   RESET        : asynchronous active-high reset
//   MODE         : pattern select (bars / checker / grey ramp / moving bar)
//   VGA_RED/GREEN/BLUE : colour channels, COLOR_W bits each
//   VGA_HS, VGA_VS     : syncs, asserted level set by HS_POL / VS_POL
//   VGA_DE       : output pixel lies in the active area
//   FRAME_START  : one-cycle pulse while pixel (0,0) is on the outputs
// All pixel outputs are registered on the pixel enable, one pe behind the counters.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int COLOR_W    = 1,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int CHECK_LOG2 = 5,
  parameter int BAR_W      = 32,
  parameter int BAR_STEP   = 4
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic [1:0]         MODE,
  output logic [COLOR_W-1:0] VGA_RED,
  output logic [COLOR_W-1:0] VGA_GREEN,
  output logic [COLOR_W-1:0] VGA_BLUE,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_DE,
  output logic               FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = (clog2(H_TOTAL) > 0) ? clog2(H_TOTAL) : 1;
  localparam int VW      = (clog2(V_TOTAL) > 0) ? clog2(V_TOTAL) : 1;
  localparam int SEG     = H_ACTIVE / 8;
  localparam int SW      = (clog2(SEG) > 0) ? clog2(SEG) : 1;
  localparam int GS      = clog2(H_ACTIVE) - COLOR_W;
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);
  localparam logic [COLOR_W-1:0] ONES = {COLOR_W{1'b1}};

  logic          pe;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          active;
  logic          hs;
  logic          vs;
  logic          line_wrap;
  logic          frame_tick;

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk       (CLOCK_50),
    .rst       (RESET),
    .pe        (pe),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .active    (active),
    .hs        (hs),
    .vs        (vs),
    .line_wrap (line_wrap),
    .frame_tick(frame_tick)
  );

  logic [1:0]    mode_q;
  logic [HW-1:0] bar_x;
  logic [HW:0]   bar_sum;
  logic [HW-1:0] bar_next;
  logic [1:0]    mode_sel_p0;
  logic [HW-1:0] bar_cur_p0;
  logic [SW-1:0] seg_cnt;
  logic [2:0]    bar_idx;
  logic          check_p0;
  logic          mbar_p0;
  logic [COLOR_W-1:0] red_p0, green_p0, blue_p0;

  assign bar_sum  = {1'b0, bar_x} + (HW+1)'(BAR_STEP);
  assign bar_next = (bar_sum >= (HW+1)'(H_ACTIVE)) ? HW'(bar_sum - (HW+1)'(H_ACTIVE))
                                                  : HW'(bar_sum);

  // Pixel (0,0) is rendered on the same pe that samples MODE and moves the bar,
  // so the new frame's settings are bypassed straight into the mux.
  assign mode_sel_p0 = frame_tick ? MODE : mode_q;
  assign bar_cur_p0  = frame_tick ? bar_next : bar_x;

  // Checker bit taken from the full-width XOR so both counters are consumed whole.
  assign check_p0 = |((32'(hcnt) ^ 32'(vcnt)) & (32'd1 << CHECK_LOG2));
  // Right edge clipping falls out of the active-area blanking.
  assign mbar_p0  = (32'(hcnt) >= 32'(bar_cur_p0)) &&
                    (32'(hcnt) <  32'(bar_cur_p0) + 32'(BAR_W));

  always_comb begin
    red_p0   = '0;
    green_p0 = '0;
    blue_p0  = '0;
    case (mode_sel_p0)
      MODE_BARS: begin
        red_p0   = {COLOR_W{~bar_idx[1]}};
        green_p0 = {COLOR_W{~bar_idx[2]}};
        blue_p0  = {COLOR_W{~bar_idx[0]}};
      end
      MODE_CHECKER: begin
        red_p0   = check_p0 ? ONES : '0;
        green_p0 = check_p0 ? ONES : '0;
        blue_p0  = check_p0 ? ONES : '0;
      end
      MODE_RAMP: begin
        red_p0   = hcnt[GS +: COLOR_W];
        green_p0 = hcnt[GS +: COLOR_W];
        blue_p0  = hcnt[GS +: COLOR_W];
      end
      default: begin
        red_p0   = mbar_p0 ? ONES : '0;
        green_p0 = mbar_p0 ? ONES : '0;
        blue_p0  = mbar_p0 ? ONES : '0;
      end
    endcase
    if (!active) begin
      red_p0   = '0;
      green_p0 = '0;
      blue_p0  = '0;
    end
  end

  // Bar index tracks hcnt/(H_ACTIVE/8) with a segment counter instead of a divider.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      seg_cnt <= '0;
      bar_idx <= '0;
    end else if (pe) begin
      if (line_wrap) begin
        seg_cnt <= '0;
        bar_idx <= '0;
      end else if (seg_cnt == SW'(SEG - 1)) begin
        seg_cnt <= '0;
        bar_idx <= bar_idx + 1'b1;
      end else begin
        seg_cnt <= seg_cnt + 1'b1;
      end
    end
  end

  // ---- stage p0 -> outputs: registered on pe, frame state updated at (0,0) ----
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      VGA_RED     <= '0;
      VGA_GREEN   <= '0;
      VGA_BLUE    <= '0;
      VGA_DE      <= 1'b0;
      VGA_HS      <= ~HS_ON;
      VGA_VS      <= ~VS_ON;
      FRAME_START <= 1'b0;
      mode_q      <= '0;
      bar_x       <= '0;
    end else begin
      FRAME_START <= frame_tick;
      if (pe) begin
        VGA_RED   <= red_p0;
        VGA_GREEN <= green_p0;
        VGA_BLUE  <= blue_p0;
        VGA_DE    <= active;
        VGA_HS    <= hs ? HS_ON : ~HS_ON;
        VGA_VS    <= vs ? VS_ON : ~VS_ON;
      end
      if (frame_tick) begin
        mode_q <= MODE;
        bar_x  <= bar_next;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen using three reduced-size instances:
//   A: CLK_DIV=2, 1-bit colour, 80x48 raster (64x40 visible)
//   B: CLK_DIV=1, 4-bit colour, 20x7 raster (16x4 visible), moving bar
//   C: CLK_DIV=1, 4-bit colour, full 1056-pixel lines, 5 lines, grey ramp
module tb_vga_pattern_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic [1:0] mode_a = 2'd0, mode_b = 2'd3, mode_c = 2'd2;

  logic       red_a, green_a, blue_a, hs_a, vs_a, de_a, fs_a;
  logic [3:0] red_b, green_b, blue_b, red_c, green_c, blue_c;
  logic       hs_b, vs_b, de_b, fs_b, hs_c, vs_c, de_c, fs_c;
  logic [2:0]  rgb_a;
  logic [11:0] rgb_b, rgb_c;
  assign rgb_a = {red_a, green_a, blue_a};
  assign rgb_b = {red_b, green_b, blue_b};
  assign rgb_c = {red_c, green_c, blue_c};

  vga_pattern_gen #(
    .CLK_DIV(2), .COLOR_W(1),
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .HS_POL(0), .VS_POL(0), .CHECK_LOG2(5), .BAR_W(8), .BAR_STEP(4)
  ) dut_a (
    .CLOCK_50(clk), .RESET(rst_a), .MODE(mode_a),
    .VGA_RED(red_a), .VGA_GREEN(green_a), .VGA_BLUE(blue_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_DE(de_a), .FRAME_START(fs_a)
  );

  vga_pattern_gen #(
    .CLK_DIV(1), .COLOR_W(4),
    .H_ACTIVE(16), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .CHECK_LOG2(1), .BAR_W(8), .BAR_STEP(4)
  ) dut_b (
    .CLOCK_50(clk), .RESET(rst_b), .MODE(mode_b),
    .VGA_RED(red_b), .VGA_GREEN(green_b), .VGA_BLUE(blue_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_DE(de_b), .FRAME_START(fs_b)
  );

  vga_pattern_gen #(
    .CLK_DIV(1), .COLOR_W(4),
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .CHECK_LOG2(1), .BAR_W(32), .BAR_STEP(4)
  ) dut_c (
    .CLOCK_50(clk), .RESET(rst_c), .MODE(mode_c),
    .VGA_RED(red_c), .VGA_GREEN(green_c), .VGA_BLUE(blue_c),
    .VGA_HS(hs_c), .VGA_VS(vs_c), .VGA_DE(de_c), .FRAME_START(fs_c)
  );

  int errors = 0;
  int checks = 0;
  int fpos   = 0;   // CLOCK_50 cycles since the last FRAME_START anchor

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic seek(input int target);
    while (fpos < target) begin
      @(negedge clk);
      fpos++;
    end
  endtask

  task automatic wait_fs(input int which, input int limit, input string tag);
    int n;
    logic f;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      f = (which == 0) ? fs_a : (which == 1) ? fs_b : fs_c;
    end while (!f && n < limit);
    chk(tag, 32'(f), 32'd1);
    fpos = 0;
  endtask

  logic [2:0] bar_exp [8];
  int bxs [4];
  int de_n, vs_n, hs_n, falls, f1, f2, fs_extra, bx, last;
  logic prev;

  initial begin
    bar_exp = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    bxs     = '{4, 8, 12, 0};

    // ---------------- instance A: reset and first pixel ----------------
    repeat (10) @(negedge clk);
    chk("rst_rgb", 32'(rgb_a), 32'd0);
    chk("rst_de",  32'(de_a),  32'd0);
    chk("rst_hs",  32'(hs_a),  32'd1);
    chk("rst_vs",  32'(vs_a),  32'd1);
    chk("rst_fs",  32'(fs_a),  32'd0);
    rst_a = 1'b0;
    @(negedge clk);
    chk("pre_pe_fs", 32'(fs_a), 32'd0);
    chk("pre_pe_de", 32'(de_a), 32'd0);
    @(negedge clk);
    chk("first_fs",  32'(fs_a),  32'd1);
    chk("first_de",  32'(de_a),  32'd1);
    chk("first_rgb", 32'(rgb_a), 32'h7);
    fpos = 0;
    @(negedge clk);
    fpos = 1;
    chk("fs_width", 32'(fs_a),  32'd0);
    chk("pix_hold", 32'(rgb_a), 32'h7);

    // ---------------- A frame 1: colour bars ----------------
    for (int k = 0; k < 8; k++) begin
      seek(2 * (8 * k + 5));
      chk($sformatf("bar%0d", k), 32'(rgb_a), 32'(bar_exp[k]));
    end
    seek(2 * 66);
    chk("hblank_rgb", 32'(rgb_a), 32'd0);
    chk("hblank_de",  32'(de_a),  32'd0);
    seek(2 * 72);
    chk("hs_on", 32'(hs_a), 32'd0);
    seek(2 * (10 * 80));
    mode_a = 2'd1;
    seek(2 * (20 * 80 + 32));
    chk("mid_frame_still_bars", 32'(rgb_a), 32'b101);
    seek(2 * (42 * 80 + 5));
    chk("vblank_de",  32'(de_a),  32'd0);
    chk("vblank_rgb", 32'(rgb_a), 32'd0);
    chk("vs_on",      32'(vs_a),  32'd0);
    seek(2 * (45 * 80));
    chk("vs_off", 32'(vs_a), 32'd1);
    seek(7680);
    chk("fs_frame2", 32'(fs_a), 32'd1);
    fpos = 0;

    // ---------------- A frame 2: checkerboard after mode change ----------------
    seek(2 * 32);
    chk("chk_32_0", 32'(rgb_a), 32'h7);
    seek(2 * (32 * 80 + 16));
    chk("chk_16_32", 32'(rgb_a), 32'h7);
    seek(2 * (32 * 80 + 32));
    chk("chk_32_32", 32'(rgb_a), 32'h0);
    seek(7680);
    chk("fs_frame3", 32'(fs_a), 32'd1);
    fpos = 0;

    // ---------------- A frame 3: whole-frame timing ----------------
    de_n = 0; vs_n = 0; hs_n = 0; falls = 0; f1 = -1; f2 = -1; fs_extra = 0;
    prev = hs_a;
    for (int i = 0; i < 7680; i++) begin
      if (i > 0) begin
        if (fs_a) fs_extra++;
        if (prev && !hs_a) begin
          falls++;
          if (f1 < 0) f1 = i;
          else if (f2 < 0) f2 = i;
        end
      end
      de_n += int'(de_a);
      vs_n += int'(!vs_a);
      hs_n += int'(!hs_a);
      prev = hs_a;
      @(negedge clk);
    end
    fpos = 0;
    chk("fs_period",     32'(fs_a),     32'd1);
    chk("fs_extra",      32'(fs_extra), 32'd0);
    chk("de_cycles",     32'(de_n),     32'd5120);
    chk("hs_low_cycles", 32'(hs_n),     32'd768);
    chk("hs_falls",      32'(falls),    32'd48);
    chk("hs_first_fall", 32'(f1),       32'd136);
    chk("hs_period",     32'(f2 - f1),  32'd160);
    chk("vs_low_cycles", 32'(vs_n),     32'd480);

    // ---------------- instance B: moving bar, clip and wrap ----------------
    rst_b = 1'b0;
    for (int f = 0; f < 4; f++) begin
      wait_fs(1, 200, $sformatf("fs_b%0d", f));
      bx = bxs[f];
      seek(0);
      chk($sformatf("mbar%0d_x0", f), 32'(rgb_b), (bx == 0) ? 32'hFFF : 32'h0);
      if (bx > 0) begin
        seek(bx - 1);
        chk($sformatf("mbar%0d_left", f), 32'(rgb_b), 32'h0);
      end
      seek(bx);
      chk($sformatf("mbar%0d_start", f), 32'(rgb_b), 32'hFFF);
      last = (bx + 7 < 16) ? bx + 7 : 15;
      seek(last);
      chk($sformatf("mbar%0d_end", f), 32'(rgb_b), 32'hFFF);
      if (bx + 8 < 16) begin
        seek(bx + 8);
        chk($sformatf("mbar%0d_right", f), 32'(rgb_b), 32'h0);
      end else begin
        seek(16);
        chk($sformatf("mbar%0d_clip_rgb", f), 32'(rgb_b), 32'h0);
        chk($sformatf("mbar%0d_clip_de", f),  32'(de_b),  32'd0);
      end
    end

    // ---------------- instance C: ramp, pe every cycle, async reset ----------------
    rst_c = 1'b0;
    wait_fs(2, 10, "fs_c");
    chk("c_first_de",  32'(de_c),  32'd1);
    chk("c_first_rgb", 32'(rgb_c), 32'h0);
    seek(63);
    chk("ramp_63", 32'(rgb_c), 32'h000);
    seek(64);
    chk("ramp_64", 32'(rgb_c), 32'h111);
    seek(300);
    chk("c_pre_rst_de", 32'(de_c), 32'd1);
    #3 rst_c = 1'b1;
    #1;
    chk("async_rst_rgb", 32'(rgb_c), 32'h0);
    chk("async_rst_de",  32'(de_c),  32'd0);
    chk("async_rst_hs",  32'(hs_c),  32'd1);
    @(negedge clk);
    rst_c = 1'b0;
    wait_fs(2, 4, "restart_fs");
    chk("restart_de",  32'(de_c),  32'd1);
    chk("restart_rgb", 32'(rgb_c), 32'h0);
    seek(400);
    chk("ramp_400", 32'(rgb_c), 32'h666);
    seek(512);
    chk("ramp_512", 32'(rgb_c), 32'h888);
    seek(799);
    chk("ramp_799", 32'(rgb_c), 32'hCCC);
    seek(800);
    chk("c_hblank_rgb", 32'(rgb_c), 32'h0);
    chk("c_hblank_de",  32'(de_c),  32'd0);
    seek(840);
    chk("c_hs_on", 32'(hs_c), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
